sound_scheduler: RTL and testbench

- Arbitrates game sound events (bad collision, good collision, snake direction change) and sequences a single shared tone generator.
- Sits between the collision/direction logic and the tone/PWM output. Gated by the mode bit from sound_fsm (`mode_o`, 1 = ON).
- Detects events, queues one pending flag per class, and grants by fixed priority.
- Times each tone, inserts a silent gap between tones, and lets a bad collision preempt lower-priority tones.

---
 rtl/sound_scheduler.sv | 166 ++++++++++++++++
 tb/tb_sound_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_scheduler.sv
// sound_scheduler
//   Arbitrates game sound events and sequences one shared tone generator.
//   Each event class (bad collision, good collision, direction change) has
//   one pending flag. Grants go by fixed priority bad > good > move. Every
//   tone is followed by a silent gap. A pending bad collision preempts a
//   lower-priority tone that is already playing.
//
// Ports
//   clk        system clock
//   nRst       asynchronous active-low reset
//   mode_i     sound enable (1 = on, 0 = muted; mute discards all events)
//   goodColl   good-collision level
//   badColl    bad-collision level
//   direction  one-hot snake direction, 4'b0000 = none
//   playSound  tone generator enable (registered)
//   tone_sel   00 none, 01 move, 10 good, 11 bad (registered)
//   busy       high while not idle or while any event is pending
module sound_scheduler #(
  parameter int                CNT_W       = 16,
  parameter logic [CNT_W-1:0]  BAD_CYCLES  = 16'd4000,
  parameter logic [CNT_W-1:0]  GOOD_CYCLES = 16'd2000,
  parameter logic [CNT_W-1:0]  MOVE_CYCLES = 16'd500,
  parameter logic [CNT_W-1:0]  GAP_CYCLES  = 16'd200
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       mode_i,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic [3:0] direction,
  output logic       playSound,
  output logic [1:0] tone_sel,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [1:0] TONE_NONE = 2'b00;
  localparam logic [1:0] TONE_MOVE = 2'b01;
  localparam logic [1:0] TONE_GOOD = 2'b10;
  localparam logic [1:0] TONE_BAD  = 2'b11;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             play_n;
  logic [1:0]       tone_n;

  logic             goodColl_q, badColl_q;
  logic [3:0]       dir_q;
  logic             pend_bad, pend_good, pend_move;
  logic             ev_bad, ev_good, ev_move;
  logic             clr_bad, clr_good, clr_move;
  logic             any_pend;

  // A held level gives one event: only a rise (or a new non-zero direction)
  // relative to the previous sample counts.
  assign ev_bad   = badColl & ~badColl_q;
  assign ev_good  = goodColl & ~goodColl_q;
  assign ev_move  = (direction != 4'b0000) && (direction != dir_q);
  assign any_pend = pend_bad | pend_good | pend_move;
  assign busy     = (state != IDLE) | any_pend;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    play_n   = playSound;
    tone_n   = tone_sel;
    clr_bad  = 1'b0;
    clr_good = 1'b0;
    clr_move = 1'b0;
    case (state)
      IDLE: begin
        play_n = 1'b0;
        tone_n = TONE_NONE;
        if (mode_i && any_pend) begin
          state_n = PLAY;
          play_n  = 1'b1;
          if (pend_bad) begin
            tone_n  = TONE_BAD;
            cnt_n   = BAD_CYCLES - ONE;
            clr_bad = 1'b1;
          end else if (pend_good) begin
            tone_n   = TONE_GOOD;
            cnt_n    = GOOD_CYCLES - ONE;
            clr_good = 1'b1;
          end else begin
            tone_n   = TONE_MOVE;
            cnt_n    = MOVE_CYCLES - ONE;
            clr_move = 1'b1;
          end
        end
      end
      PLAY: begin
        if (!mode_i) begin
          state_n = IDLE;
          play_n  = 1'b0;
          tone_n  = TONE_NONE;
        end else if (pend_bad && (tone_sel != TONE_BAD)) begin
          // Preempted tone is dropped, never re-queued.
          tone_n  = TONE_BAD;
          cnt_n   = BAD_CYCLES - ONE;
          clr_bad = 1'b1;
        end else if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = GAP_CYCLES - ONE;
          play_n  = 1'b0;
          tone_n  = TONE_NONE;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      GAP: begin
        play_n = 1'b0;
        tone_n = TONE_NONE;
        if (!mode_i || (cnt == '0)) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: begin
        state_n = IDLE;
        play_n  = 1'b0;
        tone_n  = TONE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      cnt        <= '0;
      playSound  <= 1'b0;
      tone_sel   <= TONE_NONE;
      goodColl_q <= 1'b0;
      badColl_q  <= 1'b0;
      dir_q      <= 4'b0000;
      pend_bad   <= 1'b0;
      pend_good  <= 1'b0;
      pend_move  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      playSound  <= play_n;
      tone_sel   <= tone_n;
      goodColl_q <= goodColl;
      badColl_q  <= badColl;
      dir_q      <= direction;
      // A fresh event on the grant edge re-arms its flag as a new request.
      if (!mode_i) begin
        pend_bad  <= 1'b0;
        pend_good <= 1'b0;
        pend_move <= 1'b0;
      end else begin
        pend_bad  <= (pend_bad  & ~clr_bad)  | ev_bad;
        pend_good <= (pend_good & ~clr_good) | ev_good;
        pend_move <= (pend_move & ~clr_move) | ev_move;
      end
    end
  end

endmodule

// File: tb/tb_sound_scheduler.sv
module tb_sound_scheduler;

  localparam int BAD  = 12;
  localparam int GOOD = 8;
  localparam int MOVE = 4;
  localparam int GAPC = 2;

  logic       tb_clk;
  logic       nRst;
  logic       mode_i;
  logic       goodColl;
  logic       badColl;
  logic [3:0] direction;
  logic       playSound;
  logic [1:0] tone_sel;
  logic       busy;

  int n_chk;
  int n_err;

  sound_scheduler #(
    .CNT_W       (16),
    .BAD_CYCLES  (16'd12),
    .GOOD_CYCLES (16'd8),
    .MOVE_CYCLES (16'd4),
    .GAP_CYCLES  (16'd2)
  ) dut (
    .clk       (tb_clk),
    .nRst      (nRst),
    .mode_i    (mode_i),
    .goodColl  (goodColl),
    .badColl   (badColl),
    .direction (direction),
    .playSound (playSound),
    .tone_sel  (tone_sel),
    .busy      (busy)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the sound currently heard, how many more cycles it
  // lasts, how many silent gap cycles remain, and one pending bit per class
  // (index 1 move, 2 good, 3 bad = tone code).
  int   m_tone;
  int   m_play_left;
  int   m_gap_left;
  bit   m_pend [4];
  logic m_prev_good, m_prev_bad;
  logic [3:0] m_prev_dir;

  function automatic int dur(input int t);
    case (t)
      3:       return BAD;
      2:       return GOOD;
      default: return MOVE;
    endcase
  endfunction

  task automatic model_reset();
    m_tone      = 0;
    m_play_left = 0;
    m_gap_left  = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_prev_good = 1'b0;
    m_prev_bad  = 1'b0;
    m_prev_dir  = 4'b0000;
  endtask

  task automatic model_edge();
    bit e_bad, e_good, e_move;
    if (!nRst) begin
      model_reset();
      return;
    end
    e_bad  = badColl && !m_prev_bad;
    e_good = goodColl && !m_prev_good;
    e_move = (direction != 4'b0000) && (direction != m_prev_dir);
    m_prev_bad  = badColl;
    m_prev_good = goodColl;
    m_prev_dir  = direction;
    if (!mode_i) begin
      m_tone = 0; m_play_left = 0; m_gap_left = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      return;
    end
    if (m_tone != 0) begin
      if (m_pend[3] && m_tone != 3) begin
        m_tone = 3; m_play_left = BAD; m_pend[3] = 1'b0;
      end else if (m_play_left == 1) begin
        m_tone = 0; m_play_left = 0; m_gap_left = GAPC;
      end else begin
        m_play_left--;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else begin
      for (int t = 3; t >= 1; t--) begin
        if (m_tone == 0 && m_pend[t]) begin
          m_tone = t; m_play_left = dur(t); m_pend[t] = 1'b0;
        end
      end
    end
    if (e_bad)  m_pend[3] = 1'b1;
    if (e_good) m_pend[2] = 1'b1;
    if (e_move) m_pend[1] = 1'b1;
  endtask

  // Observed-output tallies for scenario-level checks.
  int         tally [4];
  int         starts;
  logic [1:0] prev_sel;

  task automatic clear_tally();
    for (int i = 0; i < 4; i++) tally[i] = 0;
    starts = 0;
  endtask

  task automatic tick();
    bit m_busy;
    @(posedge tb_clk);
    model_edge();
    #1;
    m_busy = (m_tone != 0) || (m_gap_left != 0) || m_pend[1] || m_pend[2] || m_pend[3];
    chk("playSound", {31'd0, playSound}, (m_tone != 0) ? 32'd1 : 32'd0);
    chk("tone_sel", {30'd0, tone_sel}, m_tone);
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (playSound) tally[tone_sel]++;
    if (tone_sel != 2'b00 && tone_sel != prev_sel) starts++;
    prev_sel = tone_sel;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called at posedge+1: drops reset between edges and checks outputs
  // respond before any clock edge.
  task automatic async_reset(input string tag);
    #3;
    nRst = 1'b0;
    #1;
    model_reset();
    chk({tag, "_play"}, {31'd0, playSound}, 32'd0);
    chk({tag, "_tone"}, {30'd0, tone_sel}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    tick();
    nRst = 1'b1;
    prev_sel = 2'b00;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    prev_sel = 2'b00;
    nRst = 1'b1;
    mode_i = 1'b1;
    goodColl = 1'b0;
    badColl = 1'b0;
    direction = 4'b0000;
    model_reset();
    clear_tally();

    // 1. reset held two cycles, released off-edge
    #2 nRst = 1'b0;
    ticks(2);
    #2 nRst = 1'b1;
    chk("rst_play", {31'd0, playSound}, 32'd0);
    chk("rst_tone", {30'd0, tone_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    ticks(3);

    // 2. single good pulse
    clear_tally();
    goodColl = 1'b1;
    tick();
    goodColl = 1'b0;
    chk("t2_silent_at_k", {31'd0, playSound}, 32'd0);
    tick();
    chk("t2_on_k1", {30'd0, tone_sel}, 32'd2);
    ticks(15);
    chk("t2_len", tally[2], GOOD);
    chk("t2_starts", starts, 1);
    chk("t2_busy_end", {31'd0, busy}, 32'd0);

    // 3. good and bad on the same edge
    clear_tally();
    goodColl = 1'b1;
    badColl = 1'b1;
    tick();
    goodColl = 1'b0;
    badColl = 1'b0;
    ticks(34);
    chk("t3_bad_len", tally[3], BAD);
    chk("t3_good_len", tally[2], GOOD);
    chk("t3_starts", starts, 2);

    // 4. bad preempts a move tone two cycles in
    clear_tally();
    direction = 4'b0001;
    ticks(3);
    badColl = 1'b1;
    ticks(2);
    chk("t4_preempt", {30'd0, tone_sel}, 32'd3);
    badColl = 1'b0;
    ticks(25);
    chk("t4_move_len", tally[1], 3);
    chk("t4_bad_len", tally[3], BAD);
    chk("t4_starts", starts, 2);

    // 5a. muted events are discarded
    clear_tally();
    mode_i = 1'b0;
    goodColl = 1'b1;
    direction = 4'b0100;
    tick();
    goodColl = 1'b0;
    ticks(4);
    mode_i = 1'b1;
    ticks(15);
    chk("t5_mute_starts", starts, 0);

    // 5b. mute mid-tone
    clear_tally();
    goodColl = 1'b1;
    tick();
    goodColl = 1'b0;
    ticks(3);
    mode_i = 1'b0;
    tick();
    chk("t5_mid_play", {31'd0, playSound}, 32'd0);
    chk("t5_mid_tone", {30'd0, tone_sel}, 32'd0);
    chk("t5_mid_busy", {31'd0, busy}, 32'd0);
    mode_i = 1'b1;
    ticks(15);
    chk("t5_mid_len", tally[2], 3);
    chk("t5_mid_starts", starts, 1);

    // 6. held levels give one event each
    clear_tally();
    goodColl = 1'b1;
    direction = 4'b0010;
    ticks(30);
    goodColl = 1'b0;
    ticks(10);
    chk("t6_starts", starts, 2);
    chk("t6_good_len", tally[2], GOOD);
    chk("t6_move_len", tally[1], MOVE);
    clear_tally();
    direction = 4'b0000;
    tick();
    direction = 4'b0010;
    ticks(15);
    chk("t6_ret_starts", starts, 1);
    chk("t6_ret_len", tally[1], MOVE);

    // 1b. reset dropped mid-tone, between edges
    goodColl = 1'b1;
    tick();
    goodColl = 1'b0;
    ticks(3);
    chk("t1b_playing", {31'd0, playSound}, 32'd1);
    async_reset("t1b");
    ticks(5);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) mode_i = 1'b0;
      else if (!mode_i && $urandom_range(0, 14) == 0) mode_i = 1'b1;
      if ($urandom_range(0, 14) == 0) badColl = ~badColl;
      if ($urandom_range(0, 11) == 0) goodColl = ~goodColl;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0: direction = 4'b0000;
          1: direction = 4'b0001;
          2: direction = 4'b0010;
          3: direction = 4'b0100;
          default: direction = 4'b1000;
        endcase
      end
      if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
